psram_responder: RTL and testbench
==================================

PSRAM_RESPONDER -- requirements
Module: psram_responder

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 8, number of read dummy clocks after the last address nibble; legal range 2..15.
REQ-002 SHALL have parameter ADDR_WIDTH, default 23, backing-store byte address width.
REQ-003 SHALL have port i_clk  input  1  the single clock, which is also the QPI SCLK; all sampling and driving occur on its rising edge.
REQ-004 SHALL have port i_rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port i_psram_csn  input  1  chip select, active-low, sampled synchronously.
REQ-006 SHALL have port i_sio  input  4  SIO[3:0] lane from the initiator.
REQ-007 SHALL have port o_sio  output  4  read-data nibble.
REQ-008 SHALL have port o_sio_oe  output  1  SIO output enable; the top-level instantiates the tristate.
REQ-009 SHALL have port o_mem_addr  output  ADDR_WIDTH  backing-store byte address.
REQ-010 SHALL have port o_mem_we  output  1  one-cycle byte write strobe.
REQ-011 SHALL have port o_mem_wdata  output  8  write byte.
REQ-012 SHALL have port i_mem_rdata  input  8  read byte, valid one cycle after o_mem_addr is presented.
REQ-013 SHALL have port o_qpi_mode  output  1  high while in QPI mode.
REQ-014 SHALL have port o_state  output  3  current state encoding, for debug.

Function
REQ-015 SHALL model one 4-bit PSRAM chip; two instances serve the 8-bit bus, with upper and lower lanes forming the high and low nibbles.
REQ-016 SHALL use states SPI_CMD, QPI_CMD, ADDR, WAIT, RD_DATA, WR_DATA, IGNORE; a cycle counts when i_psram_csn=0 at the edge.
REQ-017 SPI_CMD: SHALL shift i_sio[0] MSB-first for 8 cycles; on 35h set QPI mode, otherwise ignore the command; in both cases go to IGNORE.
REQ-018 QPI_CMD: SHALL take 2 nibbles, high nibble first; EBh goes to ADDR(read), 38h to ADDR(write), F5h clears QPI mode and goes to IGNORE, and any other command goes to IGNORE.
REQ-019 ADDR: SHALL take 6 nibbles MSB-first into a 24-bit address, using the low ADDR_WIDTH bits; read goes to WAIT and write goes to WR_DATA.
REQ-020 WAIT: SHALL last exactly WAIT_CYCLES cycles; o_mem_addr SHALL be presented in its first cycle.
REQ-021 RD_DATA: o_sio_oe=1 from the first RD_DATA cycle; SHALL drive byte[7:4] on even cycles and byte[3:0] on odd cycles.
REQ-022 RD_DATA: on each high-nibble cycle, SHALL increment o_mem_addr to prefetch the next byte, so bursts are continuous.
REQ-023 WR_DATA: on the low-nibble cycle, SHALL pulse o_mem_we for one cycle with the assembled byte and the current address, then increment the address.
REQ-024 Address increment SHALL wrap modulo 2^ADDR_WIDTH.
REQ-025 IGNORE: SHALL hold until deselect.
REQ-026 i_psram_csn=1 at any edge SHALL abort the transaction, with next state SPI_CMD or QPI_CMD by mode; o_sio_oe=0 and o_mem_we=0 in the same cycle; QPI mode is retained.
REQ-027 A write byte with only its high nibble received before deselect SHALL be discarded.
REQ-028 o_sio_oe SHALL never be 1 outside RD_DATA.

Reset
REQ-029 On i_rst_n=0: state=SPI_CMD, o_qpi_mode=0, o_sio_oe=0, o_sio=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, and all shift and counter registers cleared.
REQ-030 Reset mid-transaction SHALL take effect immediately; the transaction resumes only after a fresh select.

Structure
REQ-031 SHALL place the command constants (35h, EBh, 38h, F5h) and the state enum in shared package psram_pkg, also used by psram.
REQ-032 SHALL be a single module; the backing store is external.

Verification
REQ-033 SPI 35h on sio[0], then deselect -> o_qpi_mode=1; o_sio_oe stays 0 throughout.
REQ-034 QPI 38h, addr 000010h, data A5h,3Ch -> o_mem_we pulses twice: (10h,A5h) and (11h,3Ch).
REQ-035 QPI EBh, addr 000010h, memory 10h=A5h, 11h=3Ch -> after 8 dummy cycles o_sio = A,5,3,C on consecutive cycles with o_sio_oe=1.
REQ-036 Write at addr 7FFFFFh, 2 bytes -> second write at address 0.
REQ-037 Deselect after the high nibble of a write byte -> no o_mem_we pulse; the next QPI command decodes correctly.
REQ-038 i_rst_n low during RD_DATA -> o_sio_oe=0 immediately; o_qpi_mode=0; an EBh sent in QPI mode is then ignored.

Source files
------------

// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM responder model: FSM states and command
// opcodes used by both psram and psram_responder.
package psram_pkg;

  typedef enum logic [2:0] {
    SPI_CMD = 3'd0,
    QPI_CMD = 3'd1,
    ADDR    = 3'd2,
    WAIT    = 3'd3,
    RD_DATA = 3'd4,
    WR_DATA = 3'd5,
    IGNORE  = 3'd6
  } psram_state_e;

  localparam logic [7:0] CMD_QPI_ENTER  = 8'h35;
  localparam logic [7:0] CMD_QUAD_READ  = 8'hEB;
  localparam logic [7:0] CMD_QUAD_WRITE = 8'h38;
  localparam logic [7:0] CMD_QPI_EXIT   = 8'hF5;

  // Command-phase state a deselect returns to, depending on the bus mode.
  function automatic psram_state_e idle_state(input logic qpi);
    return qpi ? QPI_CMD : SPI_CMD;
  endfunction

endpackage

// File: rtl/psram_responder.sv
// Behavioural model of one 4-bit PSRAM die responding to SPI/QPI commands.
// Two instances side by side serve an 8-bit bus (upper/lower nibble lanes).
// The byte-wide backing store lives outside this module.
module psram_responder
  import psram_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 8,
  parameter int unsigned ADDR_WIDTH  = 23
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_psram_csn,
  input  logic [3:0]            i_sio,
  output logic [3:0]            o_sio,
  output logic                  o_sio_oe,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_we,
  output logic [7:0]            o_mem_wdata,
  input  logic [7:0]            i_mem_rdata,
  output logic                  o_qpi_mode,
  output logic [2:0]            o_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]            WAIT_LAST = 4'(WAIT_CYCLES - 1);

  psram_state_e          state_q, state_d;
  logic                  qpi_q, qpi_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [ADDR_WIDTH-1:0] addr_sh_q, addr_sh_d;
  logic                  rd_q, rd_d;
  logic [3:0]            hi_q, hi_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                  we_q, we_d;
  logic [7:0]            wdata_q, wdata_d;

  // Next-state and datapath decode for one SCLK edge.
  always_comb begin
    state_d    = state_q;
    qpi_d      = qpi_q;
    cnt_d      = cnt_q;
    cmd_d      = cmd_q;
    addr_sh_d  = addr_sh_q;
    rd_d       = rd_q;
    hi_d       = hi_q;
    mem_addr_d = mem_addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;

    // The write strobe is held one cycle at the byte's address; advance after it.
    if (we_q) begin
      mem_addr_d = mem_addr_q + ADDR_ONE;
    end

    if (i_psram_csn) begin
      state_d = idle_state(qpi_q);
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        SPI_CMD: begin
          cmd_d = {cmd_q[6:0], i_sio[0]};
          if (cnt_q == 4'd7) begin
            cnt_d   = '0;
            state_d = IGNORE;
            if (cmd_d == CMD_QPI_ENTER) begin
              qpi_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        QPI_CMD: begin
          cmd_d = {cmd_q[3:0], i_sio};
          if (cnt_q == 4'd1) begin
            cnt_d = '0;
            if (cmd_d == CMD_QUAD_READ) begin
              rd_d    = 1'b1;
              state_d = ADDR;
            end else if (cmd_d == CMD_QUAD_WRITE) begin
              rd_d    = 1'b0;
              state_d = ADDR;
            end else if (cmd_d == CMD_QPI_EXIT) begin
              qpi_d   = 1'b0;
              state_d = IGNORE;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ADDR: begin
          // Upper nibbles beyond ADDR_WIDTH fall off the top of the shifter.
          addr_sh_d = {addr_sh_q[ADDR_WIDTH-5:0], i_sio};
          if (cnt_q == 4'd5) begin
            cnt_d      = '0;
            mem_addr_d = addr_sh_d;
            state_d    = rd_q ? WAIT : WR_DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        WAIT: begin
          if (cnt_q == WAIT_LAST) begin
            cnt_d   = '0;
            state_d = RD_DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        RD_DATA: begin
          cnt_d = {3'b000, ~cnt_q[0]};
          if (!cnt_q[0]) begin
            mem_addr_d = mem_addr_q + ADDR_ONE;
          end
        end
        WR_DATA: begin
          cnt_d = {3'b000, ~cnt_q[0]};
          if (!cnt_q[0]) begin
            hi_d = i_sio;
          end else begin
            we_d    = 1'b1;
            wdata_d = {hi_q, i_sio};
          end
        end
        IGNORE: begin
        end
        default: begin
          state_d = idle_state(qpi_q);
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= SPI_CMD;
      qpi_q      <= 1'b0;
      cnt_q      <= '0;
      cmd_q      <= '0;
      addr_sh_q  <= '0;
      rd_q       <= 1'b0;
      hi_q       <= '0;
      mem_addr_q <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      qpi_q      <= qpi_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      addr_sh_q  <= addr_sh_d;
      rd_q       <= rd_d;
      hi_q       <= hi_d;
      mem_addr_q <= mem_addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
    end
  end

  // Read nibble straight from the store: the address advances on the
  // high-nibble edge, so i_mem_rdata still holds the current byte during its
  // low-nibble cycle and already holds the next byte on the following one.
  always_comb begin
    o_sio_oe = (state_q == RD_DATA) && !i_psram_csn;
    o_sio    = '0;
    if (o_sio_oe) begin
      o_sio = cnt_q[0] ? i_mem_rdata[3:0] : i_mem_rdata[7:4];
    end
  end

  assign o_mem_addr  = mem_addr_q;
  assign o_mem_we    = we_q;
  assign o_mem_wdata = wdata_q;
  assign o_qpi_mode  = qpi_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_psram_responder.sv
// Directed self-checking bench for psram_responder with a small synchronous
// byte store attached.
module tb_psram_responder;
  import psram_pkg::*;

  localparam int unsigned WAIT_CYCLES = 8;
  localparam int unsigned ADDR_WIDTH  = 23;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  csn;
  logic [3:0]            sio_in;
  logic [3:0]            sio_out;
  logic                  sio_oe;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [7:0]            mem_wdata;
  logic [7:0]            mem_rdata;
  logic                  qpi_mode;
  logic [2:0]            state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  psram_responder #(
    .WAIT_CYCLES(WAIT_CYCLES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_psram_csn (csn),
    .i_sio       (sio_in),
    .o_sio       (sio_out),
    .o_sio_oe    (sio_oe),
    .o_mem_addr  (mem_addr),
    .o_mem_we    (mem_we),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_qpi_mode  (qpi_mode),
    .o_state     (state)
  );

  // Synchronous backing store: read data follows the address by one cycle.
  logic [7:0] mem [0:63];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_addr[5:0]];
    if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
  end

  // Bus monitor: log write strobes and count output-enable cycles.
  logic [31:0] wa_q [$];
  logic [7:0]  wd_q [$];
  int          oe_cnt = 0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wa_q.push_back(32'(mem_addr));
      wd_q.push_back(mem_wdata);
    end
    if (sio_oe !== 1'b0) oe_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nib(input logic [3:0] n);
    @(negedge clk);
    csn    = 1'b0;
    sio_in = n;
  endtask

  task automatic desel();
    @(negedge clk);
    csn    = 1'b1;
    sio_in = 4'h0;
  endtask

  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) nib({3'b000, b[i]});
  endtask

  task automatic qpi_byte(input logic [7:0] b);
    nib(b[7:4]);
    nib(b[3:0]);
  endtask

  task automatic qpi_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) nib(a[i*4 +: 4]);
  endtask

  task automatic get_wr(input int idx, output logic [31:0] a, output logic [31:0] d);
    if (idx < wa_q.size()) begin
      a = wa_q[idx];
      d = 32'(wd_q[idx]);
    end else begin
      a = 32'hDEAD_BEEF;
      d = 32'hDEAD_BEEF;
    end
  endtask

  initial begin
    int          w0;
    int          oe0;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  rexp [4];
    rexp = '{4'hA, 4'h5, 4'h3, 4'hC};

    // Reset state
    rst_n  = 1'b0;
    csn    = 1'b1;
    sio_in = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'(SPI_CMD));
    check("rst_qpi",   32'(qpi_mode), 0);
    check("rst_oe",    32'(sio_oe), 0);
    check("rst_sio",   32'(sio_out), 0);
    check("rst_we",    32'(mem_we), 0);
    check("rst_addr",  32'(mem_addr), 0);
    check("rst_wdata", 32'(mem_wdata), 0);
    rst_n = 1'b1;
    desel();

    // SPI 35h enters QPI mode
    oe0 = oe_cnt;
    spi_byte(8'h35);
    desel();
    @(negedge clk);
    check("spi_qpi_on",  32'(qpi_mode), 1);
    check("spi_state",   32'(state), 32'(QPI_CMD));
    check("spi_oe_none", 32'(oe_cnt - oe0), 0);

    // QPI write of two bytes at 000010h
    w0 = wa_q.size();
    qpi_byte(8'h38);
    qpi_addr(24'h000010);
    qpi_byte(8'hA5);
    qpi_byte(8'h3C);
    desel();
    @(negedge clk);
    check("wr_count", 32'(wa_q.size() - w0), 2);
    get_wr(w0, a, d);
    check("wr0_addr", a, 32'h10);
    check("wr0_data", d, 32'hA5);
    get_wr(w0 + 1, a, d);
    check("wr1_addr", a, 32'h11);
    check("wr1_data", d, 32'h3C);

    // QPI read of the same two bytes after the dummy cycles
    qpi_byte(8'hEB);
    qpi_addr(24'h000010);
    for (int i = 0; i < int'(WAIT_CYCLES); i++) begin
      nib(4'h0);
      check("wait_oe",    32'(sio_oe), 0);
      check("wait_state", 32'(state), 32'(WAIT));
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rd_oe",  32'(sio_oe), 1);
      check("rd_nib", 32'(sio_out), 32'(rexp[k]));
    end
    desel();
    @(negedge clk);
    check("rd_end_oe",    32'(sio_oe), 0);
    check("rd_end_state", 32'(state), 32'(QPI_CMD));

    // Write across the top of the address space wraps to 0
    w0 = wa_q.size();
    qpi_byte(8'h38);
    qpi_addr(24'h7FFFFF);
    qpi_byte(8'h11);
    qpi_byte(8'h22);
    desel();
    @(negedge clk);
    check("wrap_count", 32'(wa_q.size() - w0), 2);
    get_wr(w0, a, d);
    check("wrap0_addr", a, 32'h7FFFFF);
    check("wrap0_data", d, 32'h11);
    get_wr(w0 + 1, a, d);
    check("wrap1_addr", a, 32'h0);
    check("wrap1_data", d, 32'h22);

    // Half-byte write is discarded; the next command still decodes
    w0 = wa_q.size();
    qpi_byte(8'h38);
    qpi_addr(24'h000020);
    nib(4'h7);
    desel();
    @(negedge clk);
    check("half_count", 32'(wa_q.size() - w0), 0);
    check("half_state", 32'(state), 32'(QPI_CMD));
    qpi_byte(8'h38);
    qpi_addr(24'h000030);
    qpi_byte(8'h5A);
    desel();
    @(negedge clk);
    check("next_count", 32'(wa_q.size() - w0), 1);
    get_wr(w0, a, d);
    check("next_addr", a, 32'h30);
    check("next_data", d, 32'h5A);

    // Reset in the middle of a read burst
    qpi_byte(8'hEB);
    qpi_addr(24'h000011);
    repeat (WAIT_CYCLES) nib(4'h0);
    @(negedge clk);
    check("mid_rd_oe",  32'(sio_oe), 1);
    check("mid_rd_nib", 32'(sio_out), 32'h3);
    rst_n = 1'b0;
    #1;
    check("mid_rst_oe",    32'(sio_oe), 0);
    check("mid_rst_qpi",   32'(qpi_mode), 0);
    check("mid_rst_state", 32'(state), 32'(SPI_CMD));
    check("mid_rst_sio",   32'(sio_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    desel();
    oe0 = oe_cnt;
    qpi_byte(8'hEB);
    qpi_addr(24'h000010);
    nib(4'h0);
    check("post_rst_state", 32'(state), 32'(IGNORE));
    check("post_rst_qpi",   32'(qpi_mode), 0);
    repeat (12) nib(4'h0);
    desel();
    @(negedge clk);
    check("post_rst_oe", 32'(oe_cnt - oe0), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
